// File: rtl/neo_result_reader.sv
// Read side of the NEO output memory: tracks unread words, reads them from a
// synchronous RAM and streams them out through a 2-entry skid buffer with a spike flag.
module neo_result_reader #(
   parameter int unsigned N  = 8,
   parameter int unsigned M  = 16,
   parameter int unsigned CW = 16
) (
   input  logic                 Clk,
   input  logic                 reset,
   input  logic                 wr_strobe,
   output logic [$clog2(M)-1:0] raddr,
   output logic                 rd_en,
   input  logic [N-1:0]         rdata,
   input  logic [N-1:0]         thresh,
   output logic [N-1:0]         out_data,
   output logic                 out_spike,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic                 overflow,
   output logic [CW-1:0]        spike_cnt
);

   localparam int unsigned AW = $clog2(M);

   logic [AW:0]   count_q, count_d;
   logic [AW-1:0] raddr_q, raddr_d;
   logic          inflight_q;
   logic [1:0]    buf_cnt_q, buf_cnt_d;
   logic [N-1:0]  head_data_q, head_data_d, tail_data_q, tail_data_d;
   logic          head_spike_q, head_spike_d, tail_spike_q, tail_spike_d;
   logic          overflow_q, overflow_d;
   logic [CW-1:0] spike_cnt_q, spike_cnt_d;

   logic          pop, issue, cap_spike;
   logic [1:0]    kept;

   always_comb begin
      pop       = (buf_cnt_q != 2'd0) && out_ready;
      kept      = buf_cnt_q - {1'b0, pop};
      // Slot freed by this cycle's pop counts as free so a full stream keeps 1 word/cycle.
      issue     = (count_q != '0) && ((kept + {1'b0, inflight_q}) < 2'd2);
      cap_spike = (rdata >= thresh);

      count_d    = count_q;
      overflow_d = overflow_q;
      if (wr_strobe && !issue) begin
         if (count_q == (AW+1)'(M)) overflow_d = 1'b1;
         else                       count_d    = count_q + (AW+1)'(1);
      end else if (!wr_strobe && issue) begin
         count_d = count_q - (AW+1)'(1);
      end

      raddr_d = issue ? raddr_q + AW'(1) : raddr_q;

      buf_cnt_d    = kept + {1'b0, inflight_q};
      head_data_d  = head_data_q;
      head_spike_d = head_spike_q;
      tail_data_d  = tail_data_q;
      tail_spike_d = tail_spike_q;
      if (pop && (buf_cnt_q == 2'd2)) begin
         head_data_d  = tail_data_q;
         head_spike_d = tail_spike_q;
      end
      if (inflight_q) begin
         if (kept == 2'd0) begin
            head_data_d  = rdata;
            head_spike_d = cap_spike;
         end else begin
            tail_data_d  = rdata;
            tail_spike_d = cap_spike;
         end
      end

      spike_cnt_d = spike_cnt_q;
      if (pop && head_spike_q && (spike_cnt_q != '1))
         spike_cnt_d = spike_cnt_q + CW'(1);
   end

   always_ff @(posedge Clk or posedge reset) begin
      if (reset) begin
         count_q      <= '0;
         raddr_q      <= '0;
         inflight_q   <= 1'b0;
         buf_cnt_q    <= '0;
         head_data_q  <= '0;
         head_spike_q <= 1'b0;
         tail_data_q  <= '0;
         tail_spike_q <= 1'b0;
         overflow_q   <= 1'b0;
         spike_cnt_q  <= '0;
      end else begin
         count_q      <= count_d;
         raddr_q      <= raddr_d;
         inflight_q   <= issue;
         buf_cnt_q    <= buf_cnt_d;
         head_data_q  <= head_data_d;
         head_spike_q <= head_spike_d;
         tail_data_q  <= tail_data_d;
         tail_spike_q <= tail_spike_d;
         overflow_q   <= overflow_d;
         spike_cnt_q  <= spike_cnt_d;
      end
   end

   assign raddr     = raddr_q;
   assign rd_en     = issue;
   assign out_data  = head_data_q;
   assign out_spike = head_spike_q;
   assign out_valid = (buf_cnt_q != 2'd0);
   assign overflow  = overflow_q;
   assign spike_cnt = spike_cnt_q;

endmodule

// File: tb/tb_neo_result_reader.sv
// Bench for neo_result_reader: RAM + writer model, queue scoreboard in write order,
// directed scenarios followed by randomized traffic.
module tb_neo_result_reader;

   localparam int unsigned N   = 8;
   localparam int unsigned M   = 16;
   localparam int unsigned CW  = 2;
   localparam int unsigned SAT = (1 << CW) - 1;

   logic          Clk = 1'b0;
   logic          reset = 1'b0;
   logic          wr_strobe = 1'b0;
   logic [3:0]    raddr;
   logic          rd_en;
   logic [N-1:0]  rdata;
   logic [N-1:0]  thresh = '0;
   logic [N-1:0]  out_data;
   logic          out_spike;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic          overflow;
   logic [CW-1:0] spike_cnt;

   logic [N-1:0]  wdata = '0;
   logic [N-1:0]  mem [M];
   logic [3:0]    waddr;

   typedef struct { logic [N-1:0] d; logic s; } ent_t;
   ent_t        exp_q[$];
   int          err_cnt = 0;
   int          chk_cnt = 0;
   int          unread = 0;
   int unsigned exp_sc = 0;
   int unsigned hs_cnt = 0;
   int unsigned rd_pulses = 0;
   bit          sb_en = 1'b1;
   bit          prev_valid = 1'b0, prev_ready = 1'b0;
   logic [N-1:0] prev_data = '0;
   logic        prev_spike = 1'b0;
   bit          seen15 = 1'b0, wrapped = 1'b0;

   always #5 Clk = ~Clk;

   neo_result_reader #(.N(N), .M(M), .CW(CW)) u_dut (
      .Clk(Clk), .reset(reset), .wr_strobe(wr_strobe), .raddr(raddr), .rd_en(rd_en),
      .rdata(rdata), .thresh(thresh), .out_data(out_data), .out_spike(out_spike),
      .out_valid(out_valid), .out_ready(out_ready), .overflow(overflow),
      .spike_cnt(spike_cnt)
   );

   always @(posedge Clk or posedge reset) begin
      if (reset) begin
         waddr <= '0;
      end else begin
         if (wr_strobe) begin
            mem[waddr] <= wdata;
            waddr      <= waddr + 4'd1;
         end
         if (rd_en) rdata <= mem[raddr];
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      chk_cnt++;
      if (got !== exp) begin
         err_cnt++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic clear_model();
      exp_q.delete();
      unread = 0; exp_sc = 0; hs_cnt = 0; rd_pulses = 0;
      prev_valid = 1'b0; prev_ready = 1'b0;
      seen15 = 1'b0; wrapped = 1'b0;
   endtask

   // One clock: sample settled outputs mid-cycle, update the model, advance to the next negedge.
   task automatic step();
      ent_t e;
      bit   exp_spike;
      #1;
      check_eq("spike_cnt", spike_cnt, exp_sc);
      if (rd_en) check_eq("rd_en_with_nothing_unread", unread != 0, 1);
      if (prev_valid && !prev_ready) begin
         check_eq("hold_valid", out_valid, 1);
         check_eq("hold_data", out_data, prev_data);
         check_eq("hold_spike", out_spike, prev_spike);
      end
      if (out_valid && out_ready) begin
         hs_cnt++;
         if (sb_en) begin
            if (exp_q.size() == 0) begin
               check_eq("extra_word", exp_q.size(), 1);
               exp_spike = 1'b0;
            end else begin
               e = exp_q.pop_front();
               check_eq("out_data", out_data, e.d);
               check_eq("out_spike", out_spike, e.s);
               exp_spike = e.s;
            end
         end else begin
            exp_spike = (out_data >= thresh);
            check_eq("out_spike_rule", out_spike, exp_spike);
         end
         if (exp_spike && exp_sc < SAT) exp_sc++;
      end
      if (rd_en) begin
         rd_pulses++;
         if (seen15 && raddr == 4'd0) wrapped = 1'b1;
         if (raddr == 4'd15) seen15 = 1'b1;
      end
      unread = unread + int'(wr_strobe) - int'(rd_en);
      if (unread > int'(M)) unread = M;
      if (wr_strobe && sb_en) begin
         e.d = wdata;
         e.s = (wdata >= thresh);
         exp_q.push_back(e);
      end
      prev_valid = out_valid; prev_ready = out_ready;
      prev_data  = out_data;  prev_spike = out_spike;
      @(posedge Clk);
      @(negedge Clk);
   endtask

   task automatic do_reset();
      reset = 1'b1; wr_strobe = 1'b0; out_ready = 1'b0;
      clear_model();
      @(posedge Clk);
      @(negedge Clk);
      reset = 1'b0;
   endtask

   task automatic strobe(input logic [N-1:0] d);
      wr_strobe = 1'b1; wdata = d;
      step();
      wr_strobe = 1'b0;
   endtask

   task automatic drain(input string tag);
      wr_strobe = 1'b0; out_ready = 1'b1;
      for (int i = 0; i < 40; i++) step();
      check_eq({tag, "_leftover"}, exp_q.size(), 0);
      check_eq({tag, "_idle_valid"}, out_valid, 0);
   endtask

   initial begin
      do_reset();
      #1;
      check_eq("rst_out_valid", out_valid, 0);
      check_eq("rst_rd_en", rd_en, 0);
      check_eq("rst_raddr", raddr, 0);
      check_eq("rst_overflow", overflow, 0);

      // Single word: two-clock latency, spike, raddr advance
      thresh = 8'h30; out_ready = 1'b1;
      strobe(8'h40);
      #1;
      check_eq("t2_rd_en", rd_en, 1);
      check_eq("t2_raddr0", raddr, 0);
      check_eq("t2_valid_e0", out_valid, 0);
      step();
      check_eq("t2_valid_e1", out_valid, 0);
      check_eq("t2_raddr1", raddr, 1);
      step();
      check_eq("t2_valid_e2", out_valid, 1);
      check_eq("t2_data", out_data, 8'h40);
      check_eq("t2_spike", out_spike, 1);
      step();
      check_eq("t2_spike_cnt", spike_cnt, 1);
      drain("t2");

      // Backpressure: only two reads outstanding, then back-to-back release
      do_reset();
      thresh = 8'h11;
      for (int i = 0; i < 4; i++) strobe(8'h10 + 8'(i));
      for (int i = 0; i < 4; i++) step();
      check_eq("t3_rd_pulses", rd_pulses, 2);
      check_eq("t3_head_held", out_data, 8'h10);
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1;
         check_eq("t3_stream_valid", out_valid, 1);
         check_eq("t3_stream_data", out_data, 8'h10 + 8'(i));
         step();
      end
      drain("t3");

      // 20 words at full rate: raddr wraps, no bubbles, no overflow
      do_reset();
      thresh = 8'h80; out_ready = 1'b1;
      begin
         int unsigned gaps = 0;
         for (int i = 0; i < 20; i++) begin
            wr_strobe = 1'b1; wdata = N'($urandom);
            #1;
            if (hs_cnt > 0 && !out_valid) gaps++;
            step();
         end
         wr_strobe = 1'b0;
         for (int i = 0; i < 10 && hs_cnt < 20; i++) begin
            #1;
            if (!out_valid) gaps++;
            step();
         end
         check_eq("t4_gaps", gaps, 0);
      end
      check_eq("t4_delivered", hs_cnt, 20);
      check_eq("t4_wrapped", wrapped, 1);
      check_eq("t4_raddr", raddr, 4);
      check_eq("t4_overflow", overflow, 0);
      drain("t4");

      // Overflow: 19 strobes with the consumer stalled
      do_reset();
      sb_en = 1'b0; thresh = 8'hFF;
      for (int i = 0; i < 18; i++) strobe(8'h20 + 8'(i));
      check_eq("t5_no_overflow_yet", overflow, 0);
      strobe(8'h40);
      check_eq("t5_overflow_set", overflow, 1);
      check_eq("t5_unread_cap", unread, M);
      hs_cnt = 0;
      drain("t5");
      check_eq("t5_drained_words", hs_cnt, 18);
      check_eq("t5_overflow_sticky", overflow, 1);
      sb_en = 1'b1;

      // Threshold edge and counter saturation
      do_reset();
      thresh = 8'hFF; out_ready = 1'b1;
      strobe(8'hFE);
      strobe(8'hFF);
      for (int i = 0; i < 3; i++) strobe(8'hFF);
      drain("t6");
      check_eq("t6_spike_sat", spike_cnt, SAT);

      // Threshold change after capture must not alter buffered flags
      do_reset();
      thresh = 8'h80;
      strobe(8'h90);
      strobe(8'h70);
      for (int i = 0; i < 4; i++) step();
      thresh = 8'h60;
      step();
      drain("thr_change");

      // Reset mid-stream, then next word read from address 0
      do_reset();
      thresh = 8'h00; out_ready = 1'b1;
      strobe(8'h33);
      drain("t1_pre");
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) strobe(8'h50 + 8'(i));
      step(); step();
      check_eq("t1_valid_before", out_valid, 1);
      #2;
      reset = 1'b1;
      #1;
      check_eq("t1_valid", out_valid, 0);
      check_eq("t1_data", out_data, 0);
      check_eq("t1_spike", out_spike, 0);
      check_eq("t1_rd_en", rd_en, 0);
      check_eq("t1_raddr", raddr, 0);
      check_eq("t1_spike_cnt", spike_cnt, 0);
      clear_model();
      @(negedge Clk);
      reset = 1'b0;
      out_ready = 1'b1;
      strobe(8'h5A);
      #1;
      check_eq("t1_post_rd_en", rd_en, 1);
      check_eq("t1_post_raddr", raddr, 0);
      drain("t1_post");

      // Randomized traffic, writer never overruns
      do_reset();
      thresh = N'($urandom);
      for (int seg = 0; seg < 20; seg++) begin
         int unsigned rprob = $urandom_range(0, 3);
         for (int i = 0; i < 20; i++) begin
            out_ready = ($urandom_range(0, 3) < rprob) || (rprob == 3);
            wr_strobe = ($urandom_range(0, 1) == 1) && (unread < int'(M));
            wdata = N'($urandom);
            step();
         end
      end
      wr_strobe = 1'b0;
      drain("rand");
      check_eq("rand_overflow", overflow, 0);

      $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
      $finish;
   end

endmodule
